// File: rtl/vx_mask_iterator.sv
// Serialises a multi-hot mask into one set-bit index per cycle, ascending or (REVERSE) descending.
// Valid/ready on both sides; a new mask can be taken on the final fire of the previous one.
module vx_mask_iterator #(
    parameter int N       = 8,
    parameter int REVERSE = 0,
    parameter int LN      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    input  logic [N-1:0]  data_in,
    output logic          ready_in,
    output logic          valid_out,
    output logic [LN-1:0] index_out,
    output logic [N-1:0]  onehot_out,
    output logic          last_out,
    input  logic          ready_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] remaining_q, remaining_d;

    logic [N-1:0]  scan_mask;
    logic [N-1:0]  scan_first;
    logic [N-1:0]  first_bit;
    logic [LN-1:0] first_index;
    logic          single_bit;
    logic          busy;
    logic          fire;
    logic          accept;

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] x);
        logic [N-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < N; k++) begin
            r[k] = x[N-1-k];
        end
        return r;
    endfunction

    // OR-of-positions encoder; input is one-hot so no priority is involved
    function automatic logic [LN-1:0] encode(input logic [N-1:0] oh);
        logic [LN-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = idx | (oh[k] ? LN'(k) : '0);
        end
        return idx;
    endfunction

    // Reverse mode mirrors the mask so one x & -x isolates the highest bit and
    // the encoded mirrored position is directly the reported N-1-i index.
    always_comb begin : find_first
        scan_mask   = (REVERSE != 0) ? bit_rev(remaining_q) : remaining_q;
        scan_first  = scan_mask & (~scan_mask + N'(1));
        first_bit   = (REVERSE != 0) ? bit_rev(scan_first) : scan_first;
        first_index = encode(scan_first);
        single_bit  = (remaining_q != '0) &&
                      ((remaining_q & (remaining_q - N'(1))) == '0);
    end

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin : next_state
        state_d     = state_q;
        remaining_d = remaining_q;
        if (accept) begin
            remaining_d = data_in;
            state_d     = (data_in != '0) ? ST_BUSY : ST_IDLE;
        end else if (fire) begin
            remaining_d = remaining_q & ~first_bit;
            if (single_bit) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin : outputs
        busy       = (state_q == ST_BUSY);
        valid_out  = busy;
        onehot_out = busy ? first_bit : '0;
        index_out  = busy ? first_index : '0;
        last_out   = busy & single_bit;
        fire       = busy & ready_out;
        ready_in   = ~reset & (~busy | (fire & single_bit));
        accept     = valid_in & ready_in;
    end

    a_hold_under_backpressure: assert property (
        @(posedge clk) disable iff (reset)
        (valid_out && !ready_out) |=>
            (valid_out && $stable(index_out) && $stable(onehot_out) && $stable(last_out))
    );

    a_index_in_range: assert property (
        @(posedge clk) disable iff (reset)
        valid_out |-> (int'(index_out) < N)
    );

endmodule

// File: tb/tb_vx_mask_iterator.sv
// Bench for vx_mask_iterator: four configurations against a queue-of-indices reference model,
// directed scenarios followed by randomized traffic and resets.
module tb_vx_mask_iterator;

    localparam int NI = 4;
    localparam int NS [NI] = '{8, 8, 5, 1};
    localparam int RS [NI] = '{0, 1, 0, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           vin  [NI];
    logic [7:0]     din  [NI];
    logic           rout [NI];

    logic [NI-1:0]       rin_w, vo_w, last_w;
    logic [NI-1:0][7:0]  oh_w, idx_w;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NN = NS[g];
        localparam int LL = (NN > 1) ? $clog2(NN) : 1;
        logic [NN-1:0] oh;
        logic [LL-1:0] ix;
        logic          ri, vo, la;

        vx_mask_iterator #(.N(NN), .REVERSE(RS[g])) u_dut (
            .clk        (clk),
            .reset      (reset),
            .valid_in   (vin[g]),
            .data_in    (din[g][NN-1:0]),
            .ready_in   (ri),
            .valid_out  (vo),
            .index_out  (ix),
            .onehot_out (oh),
            .last_out   (la),
            .ready_out  (rout[g])
        );

        assign rin_w[g]  = ri;
        assign vo_w[g]   = vo;
        assign last_w[g] = la;
        assign oh_w[g]   = 8'(oh);
        assign idx_w[g]  = 8'(ix);
    end

    // Reference: per instance, the queue of indices still owed to the consumer
    int  expq [NI][$];
    int  seen [NI][$];
    bit  acc_flag [NI];
    bit  post_reset;
    int  n_checks;
    int  n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        #1;
        for (int i = 0; i < NI; i++) begin
            int n, sz, k, pos;
            bit exp_rdy, fire, acc;
            n  = NS[i];
            sz = expq[i].size();
            if (reset) begin
                check_eq($sformatf("u%0d.ready_in_in_reset", i), 32'(rin_w[i]), 32'd0);
                expq[i].delete();
                acc_flag[i] = 1'b0;
            end else begin
                exp_rdy = (sz == 0) || (rout[i] && sz == 1);
                check_eq($sformatf("u%0d.ready_in", i), 32'(rin_w[i]), 32'(exp_rdy));
                check_eq($sformatf("u%0d.valid_out", i), 32'(vo_w[i]), 32'(sz != 0));
                if (sz != 0) begin
                    k   = expq[i][0];
                    pos = (RS[i] != 0) ? n - 1 - k : k;
                    check_eq($sformatf("u%0d.index_out", i), 32'(idx_w[i]), 32'(k));
                    check_eq($sformatf("u%0d.onehot_out", i), 32'(oh_w[i]), 32'(1) << pos);
                    check_eq($sformatf("u%0d.last_out", i), 32'(last_w[i]), 32'(sz == 1));
                end else if (post_reset) begin
                    check_eq($sformatf("u%0d.index_after_reset", i), 32'(idx_w[i]), 32'd0);
                    check_eq($sformatf("u%0d.onehot_after_reset", i), 32'(oh_w[i]), 32'd0);
                    check_eq($sformatf("u%0d.last_after_reset", i), 32'(last_w[i]), 32'd0);
                end
                if (vo_w[i] && rout[i]) seen[i].push_back(int'(idx_w[i]));
                fire = (sz != 0) && rout[i];
                if (fire) void'(expq[i].pop_front());
                acc = vin[i] && exp_rdy;
                acc_flag[i] = acc;
                if (acc) begin
                    for (int s = 0; s < n; s++) begin
                        pos = (RS[i] != 0) ? n - 1 - s : s;
                        if (din[i][pos]) expq[i].push_back(s);
                    end
                end
            end
        end
        post_reset = reset;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input int i, input logic [7:0] m);
        int guard;
        guard  = 0;
        vin[i] = 1'b1;
        din[i] = m;
        do begin
            tick();
            guard++;
        end while (!acc_flag[i] && guard < 50);
        vin[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int guard;
        guard = 0;
        while (expq[i].size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
    endtask

    task automatic check_seen(input int i, input string tag, input int exp[$]);
        check_eq({tag, ".count"}, 32'(seen[i].size()), 32'(exp.size()));
        for (int j = 0; j < exp.size() && j < seen[i].size(); j++) begin
            check_eq($sformatf("%s[%0d]", tag, j), 32'(seen[i][j]), 32'(exp[j]));
        end
        seen[i].delete();
    endtask

    initial begin
        int e[$];
        n_checks   = 0;
        n_errors   = 0;
        post_reset = 1'b0;
        reset      = 1'b1;
        for (int i = 0; i < NI; i++) begin
            vin[i] = 1'b0; din[i] = '0; rout[i] = 1'b1; acc_flag[i] = 1'b0;
        end
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Ascending: 1001_0110 -> 1,2,4,7
        offer(0, 8'b1001_0110);
        drain(0);
        e = {1, 2, 4, 7};
        check_seen(0, "asc", e);

        // Descending: same mask -> 0,3,5,6
        offer(1, 8'b1001_0110);
        drain(1);
        e = {0, 3, 5, 6};
        check_seen(1, "desc", e);

        // Back-to-back: 0x01 then 0x80 taken on the last fire
        vin[0] = 1'b1; din[0] = 8'h01;
        tick();
        din[0] = 8'h80;
        tick();
        vin[0] = 1'b0;
        drain(0);
        e = {0, 7};
        check_seen(0, "b2b", e);

        // Zero mask dropped, then 0x0C held off for three cycles
        offer(0, 8'h00);
        tick();
        vin[0] = 1'b1; din[0] = 8'h0C;
        tick();
        vin[0] = 1'b0; rout[0] = 1'b0;
        tick(); tick(); tick();
        rout[0] = 1'b1;
        drain(0);
        e = {2, 3};
        check_seen(0, "bp", e);

        // Reset after two indices of 0xFF, then a fresh 0x20
        offer(0, 8'hFF);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        offer(0, 8'h20);
        drain(0);
        e = {0, 1, 5};
        check_seen(0, "rst", e);

        // N=5 and N=1
        offer(2, 8'b0001_0001);
        drain(2);
        e = {0, 4};
        check_seen(2, "n5", e);
        offer(3, 8'h01);
        drain(3);
        e = {0};
        check_seen(3, "n1", e);

        // Randomized traffic, backpressure and occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                vin[i]  = ($urandom_range(0, 2) != 0);
                din[i]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                rout[i] = ($urandom_range(0, 3) != 0);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            vin[i] = 1'b0; rout[i] = 1'b1;
        end
        for (int i = 0; i < NI; i++) drain(i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
